// File: rtl/sram_march_bist.sv
// March BIST engine for a single-port SRAM: E0 up-write A, E1 down-read A,
// E2 up-write B, E3 up-read B, with a READ_LATENCY-deep compare pipeline.
module sram_march_bist #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              BIST_start,
    output logic [ADDR_W-1:0] BIST_address,
    output logic [DATA_W-1:0] BIST_write_data,
    output logic              BIST_we_n,
    input  logic [DATA_W-1:0] BIST_read_data,
    output logic              BIST_finish,
    output logic              BIST_mismatch,
    output logic [ADDR_W-1:0] BIST_fail_address,
    output logic [15:0]       BIST_error_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DRN_W = 2;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_END
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          elem_q, elem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_n_q, we_n_d;
    logic                finish_q, finish_d;
    logic                mism_q, mism_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [DRN_W-1:0]    drain_q, drain_d;
    logic                start_q;

    logic                pv_q [READ_LATENCY];
    logic [ADDR_W-1:0]   pa_q [READ_LATENCY];
    logic [DATA_W-1:0]   pe_q [READ_LATENCY];

    logic                desc_c;
    logic                terminal_c;
    logic [ADDR_W-1:0]   addr_step_c;
    logic [DATA_W-1:0]   pattern_c;
    logic [1:0]          nxt_elem_c;
    logic [ADDR_W-1:0]   nxt_base_c;
    logic                start_edge_c;
    logic                cmp_fail_c;

    // Element decode: only E1 sweeps downward; E2/E3 use the inverted background.
    always_comb begin
        desc_c       = (elem_q == 2'd1);
        terminal_c   = desc_c ? (addr_q == '0) : (addr_q == '1);
        addr_step_c  = desc_c ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        pattern_c    = elem_q[1] ? ~addr_q[DATA_W-1:0] : addr_q[DATA_W-1:0];
        nxt_elem_c   = elem_q + 2'd1;
        nxt_base_c   = (nxt_elem_c == 2'd1) ? '1 : '0;
        start_edge_c = BIST_start && !start_q;
        cmp_fail_c   = pv_q[READ_LATENCY-1] &&
                       (BIST_read_data != pe_q[READ_LATENCY-1]);
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        we_n_d      = we_n_q;
        finish_d    = finish_q;
        mism_d      = mism_q;
        fail_addr_d = fail_addr_q;
        err_cnt_d   = err_cnt_q;
        drain_d     = drain_q;

        if (cmp_fail_c) begin
            mism_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (!mism_q) begin
                fail_addr_d = pa_q[READ_LATENCY-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge_c) begin
                    mism_d      = 1'b0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    finish_d    = 1'b0;
                    elem_d      = 2'd0;
                    addr_d      = '0;
                    we_n_d      = 1'b0;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (terminal_c) begin
                    elem_d  = nxt_elem_c;
                    addr_d  = nxt_base_c;
                    we_n_d  = nxt_elem_c[0];
                    state_d = nxt_elem_c[0] ? S_READ : S_WRITE;
                end else begin
                    addr_d = addr_step_c;
                end
            end
            S_READ: begin
                drain_d = '0;
                if (terminal_c) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_step_c;
                end
            end
            S_DRAIN: begin
                // Hold the address until the last issued read has been compared.
                if (drain_q == DRN_LAST) begin
                    if (elem_q == 2'd3) begin
                        state_d = S_END;
                    end else begin
                        elem_d  = nxt_elem_c;
                        addr_d  = nxt_base_c;
                        we_n_d  = nxt_elem_c[0];
                        state_d = nxt_elem_c[0] ? S_READ : S_WRITE;
                    end
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            S_END: begin
                finish_d = 1'b1;
                we_n_d   = 1'b1;
                addr_d   = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            elem_q      <= 2'd0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            finish_q    <= 1'b0;
            mism_q      <= 1'b0;
            fail_addr_q <= '0;
            err_cnt_q   <= '0;
            drain_q     <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            we_n_q      <= we_n_d;
            finish_q    <= finish_d;
            mism_q      <= mism_d;
            fail_addr_q <= fail_addr_d;
            err_cnt_q   <= err_cnt_d;
            drain_q     <= drain_d;
            start_q     <= BIST_start;
        end
    end

    // Read-compare pipeline: stage 0 captures the read issued this cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= (state_q == S_READ);
            pa_q[0] <= addr_q;
            pe_q[0] <= pattern_c;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    assign BIST_address      = addr_q;
    assign BIST_write_data   = pattern_c;
    assign BIST_we_n         = we_n_q;
    assign BIST_finish       = finish_q;
    assign BIST_mismatch     = mism_q;
    assign BIST_fail_address = fail_addr_q;
    assign BIST_error_count  = err_cnt_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench: three engines (read latency 1, 2, 4) on 16-word SRAM models
// share start/reset; a negedge monitor checks queued snapshots and run results.
module tb_sram_march_bist;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 4;
    localparam int          NI = 3;
    localparam int          NW = 2 ** AW;

    typedef struct {
        int            cyc;
        logic          status;
        logic          we_n;
        logic [AW-1:0] addr;
        logic          fin;
        logic          mm;
        logic [15:0]   cnt;
        logic [AW-1:0] fa;
    } snap_t;

    typedef struct {
        int            cyc;
        logic          mm;
        logic [15:0]   cnt;
        logic [AW-1:0] fa;
    } run_t;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          BIST_start;
    int            fault = 0;
    int            cyc = 0;
    logic          done = 1'b0;
    int            checks = 0;
    int            errors = 0;

    logic [AW-1:0] addr_w [NI];
    logic [DW-1:0] wd_w   [NI];
    logic          we_w   [NI];
    logic          fin_w  [NI];
    logic          mm_w   [NI];
    logic [AW-1:0] fa_w   [NI];
    logic [15:0]   cnt_w  [NI];

    snap_t snap_q [NI][$];
    run_t  run_q  [NI][$];

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic int run_len(input int lat);
        return 4 * NW + 2 * lat + 1;
    endfunction

    // Expected bus state k cycles after the start-detect edge.
    function automatic snap_t trace_at(input int c, input int k, input int lat);
        snap_t s;
        s.cyc = c; s.status = 1'b0; s.fin = 1'b0; s.we_n = 1'b1;
        s.mm = 1'b0; s.cnt = '0; s.fa = '0; s.addr = '0;
        if (k < NW) begin
            s.we_n = 1'b0; s.addr = AW'(k);
        end else if (k < 2 * NW) begin
            s.addr = AW'(2 * NW - 1 - k);
        end else if (k < 2 * NW + lat) begin
            s.addr = '0;
        end else if (k < 3 * NW + lat) begin
            s.we_n = 1'b0; s.addr = AW'(k - 2 * NW - lat);
        end else if (k < 4 * NW + lat) begin
            s.addr = AW'(k - 3 * NW - lat);
        end else if (k <= 4 * NW + 2 * lat) begin
            s.addr = '1;
        end else begin
            s.fin = 1'b1;
        end
        return s;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [DW-1:0] mem [NW];
        logic [AW-1:0] ap  [LAT];
        logic [DW-1:0] rd;

        always @(posedge Clock) begin
            if (!we_w[g]) mem[addr_w[g]] <= wd_w[g];
            ap[0] <= addr_w[g];
            for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
        end

        // fault 1: bit 0 of word 5 stuck at 1; fault 2: every read returns 0
        always_comb begin
            rd = mem[ap[LAT-1]];
            if (fault == 2) rd = '0;
            else if (fault == 1 && ap[LAT-1] == AW'(5)) rd = rd | DW'(1);
        end

        sram_march_bist #(
            .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)
        ) u_dut (
            .Clock            (Clock),
            .Resetn           (Resetn),
            .BIST_start       (BIST_start),
            .BIST_address     (addr_w[g]),
            .BIST_write_data  (wd_w[g]),
            .BIST_we_n        (we_w[g]),
            .BIST_read_data   (rd),
            .BIST_finish      (fin_w[g]),
            .BIST_mismatch    (mm_w[g]),
            .BIST_fail_address(fa_w[g]),
            .BIST_error_count (cnt_w[g])
        );
    end

    task automatic wait_k(input int d, input int k);
        while (cyc < d + 1 + k) @(negedge Clock);
    endtask

    task automatic push_status_all(input int c, input logic we_n, input logic [AW-1:0] addr,
                                   input logic fin, input logic mm, input logic [15:0] cnt,
                                   input logic [AW-1:0] fa);
        for (int i = 0; i < NI; i++)
            snap_q[i].push_back('{c, 1'b1, we_n, addr, fin, mm, cnt, fa});
    endtask

    task automatic start_run(output int d, input int hold, input logic trace, input logic push,
                             input logic mm, input logic [15:0] cnt, input logic [15:0] cnt1,
                             input logic [AW-1:0] fa);
        @(negedge Clock);
        d = cyc;
        BIST_start = 1'b1;
        for (int i = 0; i < NI; i++) begin
            if (push)
                run_q[i].push_back('{d + 1 + run_len(lat_of(i)), mm, (i == 1) ? cnt1 : cnt, fa});
            if (trace)
                for (int k = 0; k <= run_len(lat_of(i)); k++)
                    snap_q[i].push_back(trace_at(d + 1 + k, k, lat_of(i)));
        end
        repeat (hold) @(negedge Clock);
        BIST_start = 1'b0;
    endtask

    // Monitor: compares scheduled snapshots and each rising BIST_finish.
    initial begin
        snap_t s;
        run_t  r;
        logic  fin_prev [NI];
        logic  final_done;
        final_done = 1'b0;
        for (int i = 0; i < NI; i++) fin_prev[i] = 1'b0;
        forever begin
            @(negedge Clock);
            for (int i = 0; i < NI; i++) begin
                if (snap_q[i].size() != 0 && snap_q[i][0].cyc == cyc) begin
                    s = snap_q[i].pop_front();
                    checks++;
                    if (addr_w[i] !== s.addr || we_w[i] !== s.we_n || fin_w[i] !== s.fin ||
                        (s.status && (mm_w[i] !== s.mm || cnt_w[i] !== s.cnt || fa_w[i] !== s.fa))) begin
                        errors++;
                        $display("FAIL snap lat=%0d cyc=%0d: got addr=%h we_n=%b fin=%b mm=%b cnt=%h fa=%h, want addr=%h we_n=%b fin=%b mm=%b cnt=%h fa=%h (status %b)",
                                 lat_of(i), cyc, addr_w[i], we_w[i], fin_w[i], mm_w[i], cnt_w[i], fa_w[i],
                                 s.addr, s.we_n, s.fin, s.mm, s.cnt, s.fa, s.status);
                    end
                end
                if (fin_w[i] && !fin_prev[i]) begin
                    checks++;
                    if (run_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL run lat=%0d: unexpected finish at cyc=%0d", lat_of(i), cyc);
                    end else begin
                        r = run_q[i].pop_front();
                        if (cyc != r.cyc || mm_w[i] !== r.mm || cnt_w[i] !== r.cnt || fa_w[i] !== r.fa) begin
                            errors++;
                            $display("FAIL run lat=%0d: got cyc=%0d mm=%b cnt=%h fa=%h, want cyc=%0d mm=%b cnt=%h fa=%h",
                                     lat_of(i), cyc, mm_w[i], cnt_w[i], fa_w[i], r.cyc, r.mm, r.cnt, r.fa);
                        end
                    end
                end
                fin_prev[i] = fin_w[i];
            end
            if (done && !final_done) begin
                final_done = 1'b1;
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (run_q[i].size() != 0 || snap_q[i].size() != 0) begin
                        errors++;
                        $display("FAIL leftover lat=%0d: runs=%0d snaps=%0d, want 0 and 0",
                                 lat_of(i), run_q[i].size(), snap_q[i].size());
                    end
                end
            end
        end
    end

    initial begin
        int d;
        snap_t s;
        Resetn = 1'b0;
        BIST_start = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        push_status_all(cyc + 1, 1'b1, '0, 1'b0, 1'b0, 16'h0, '0);
        repeat (3) @(negedge Clock);

        // Clean pass with full bus trace: finish 4*16+2L+1 cycles after detect.
        fault = 0;
        start_run(d, 1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, '0);
        wait_k(d, run_len(4) + 8);

        // Stuck bit 0 at word 5: E1 reads 5 (passes), E3 expects 0xA and sees 0xB.
        fault = 1;
        start_run(d, 1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1, AW'(5));
        wait_k(d, run_len(4) + 8);

        // All-zero reads: E1 fails at 15..1, E3 at 0..14 -> 30; first failure is E1 @15.
        // A mid-run start pulse is ignored; on lat=2 the counter is preset to FFFE in E2.
        fault = 2;
        start_run(d, 1, 1'b0, 1'b1, 1'b1, 16'd30, 16'hFFFF, AW'(15));
        wait_k(d, 20);
        BIST_start = 1'b1;
        @(negedge Clock);
        BIST_start = 1'b0;
        wait_k(d, 40);
        force g_dut[1].u_dut.err_cnt_q = 16'hFFFE;
        #1;
        release g_dut[1].u_dut.err_cnt_q;
        wait_k(d, run_len(4) + 8);

        // Restart after a failing run clears the status at the detect edge.
        fault = 0;
        start_run(d, 1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, '0);
        wait_k(d, run_len(4) + 8);
        // (status snapshot pushed late would be stale; check the next run instead)

        // Start held high for 100 cycles: exactly one run, then idle with finish high.
        start_run(d, 100, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, '0);
        push_status_all(cyc + 2, 1'b1, '0, 1'b1, 1'b0, 16'h0, '0);
        wait_k(d, 120);

        // Reset mid-run during E2 of a failing run.
        fault = 2;
        @(negedge Clock);
        d = cyc;
        BIST_start = 1'b1;
        for (int i = 0; i < NI; i++) begin
            snap_q[i].push_back('{d + 2, 1'b1, 1'b0, AW'(1), 1'b0, 1'b0, 16'h0, '0});
            s = trace_at(d + 41, 40, lat_of(i));
            s.status = 1'b1; s.mm = 1'b1; s.cnt = 16'd15; s.fa = AW'(15);
            snap_q[i].push_back(s);
            snap_q[i].push_back('{d + 42, 1'b1, 1'b1, '0, 1'b0, 1'b0, 16'h0, '0});
        end
        @(negedge Clock);
        BIST_start = 1'b0;
        wait_k(d, 40);
        @(posedge Clock);
        #1;
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        // Fresh run after reset completes normally.
        fault = 0;
        start_run(d, 1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, '0);
        wait_k(d, run_len(4) + 8);

        done = 1'b1;
        repeat (3) @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
